mul_issue_ctrl: RTL and testbench



---
 rtl/mul_ctrl_pkg.sv | 32 +++
 rtl/mul_ctrl_fifo.sv | 69 ++++++
 rtl/mul_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_mul_issue_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared types for the multiplier issue controller.
package mul_ctrl_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned PKG_TAG_W  = 4;
    localparam int unsigned PKG_DATA_W = 32;

    // IEEE exception flags as returned by the datapath.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } mul_flags_t;

    // One tracker stage: follows an operation through the datapath.
    typedef struct packed {
        logic                 v;
        logic                 id;
        logic [PKG_TAG_W-1:0] tag;
    } trk_ent_t;

    // One response FIFO entry.
    typedef struct packed {
        logic                  id;
        logic [PKG_TAG_W-1:0]  tag;
        logic [PKG_DATA_W-1:0] res;
        mul_flags_t            flags;
    } rsp_ent_t;

endpackage

// File: rtl/mul_ctrl_fifo.sv
// Synchronous FIFO with asynchronous reset. No write-to-read bypass: an entry
// written this cycle becomes visible at the head next cycle. Head reads as
// zero while empty.
module mul_ctrl_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   wr_en_i,
    input  entry_t wr_data_i,
    output logic   full_o,
    input  logic   rd_en_i,
    output logic   rd_valid_o,
    output entry_t rd_data_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_wr, do_rd;

    // Pointer and occupancy next-state; overflow writes are dropped.
    always_comb begin
        full_o     = (cnt_q == CNT_W'(DEPTH));
        rd_valid_o = (cnt_q != '0);
        do_wr      = wr_en_i && !full_o;
        do_rd      = rd_en_i && rd_valid_o;
        rd_data_o  = rd_valid_o ? mem_q[rptr_q] : '0;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        if (do_wr) begin
            wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
        end
        if (do_wr && !do_rd) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_wr && do_rd) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Round-robin issue controller sharing one fixed-latency multiplier datapath
// between two requesters. Credits cover in-flight plus queued results so the
// free-running datapath can never overrun the response FIFO.
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned PIPE_D = 4,
    parameter int unsigned FIFO_D = 6,
    parameter int unsigned TAG_W  = PKG_TAG_W,
    parameter int unsigned DATA_W = PKG_DATA_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_b,
    input  logic [NUM_REQ-1:0][1:0]          req_rnd,
    output logic                             dp_valid,
    output logic [DATA_W-1:0]                dp_a,
    output logic [DATA_W-1:0]                dp_b,
    output logic [1:0]                       dp_rnd,
    input  logic [DATA_W-1:0]                dp_res,
    input  logic [4:0]                       dp_flags,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic                             rsp_id,
    output logic [TAG_W-1:0]                 rsp_tag,
    output logic [DATA_W-1:0]                rsp_res,
    output logic [4:0]                       rsp_flags
);

    localparam int unsigned OCC_W = $clog2(FIFO_D + 1);

    // Entry structs are fixed-width; reject overrides they cannot carry.
    if (TAG_W != PKG_TAG_W || DATA_W != PKG_DATA_W || PIPE_D < 1 || FIFO_D < 1) begin : g_param_check
        $error("mul_issue_ctrl: unsupported parameter combination");
    end

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             prio_q, prio_d;
    logic             issue_ok, gnt_any, gnt_id, pop;
    trk_ent_t         trk_q [PIPE_D];
    trk_ent_t         trk_d [PIPE_D];
    rsp_ent_t         fifo_wdata, fifo_head;
    logic             fifo_wr, fifo_full;

    // Arbitration and operand mux; credit check never looks at rsp_ready.
    always_comb begin
        issue_ok = !rst && (occ_q < OCC_W'(FIFO_D));
        case (req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = prio_q;
            default: gnt_id = 1'b0;
        endcase
        gnt_any   = issue_ok && (req_valid != '0);
        req_ready = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
        dp_valid  = gnt_any;
        dp_a      = gnt_any ? req_a[gnt_id]   : '0;
        dp_b      = gnt_any ? req_b[gnt_id]   : '0;
        dp_rnd    = gnt_any ? req_rnd[gnt_id] : '0;
        prio_d    = gnt_any ? ~gnt_id : prio_q;
    end

    // Tracker shifts every cycle, matching the enable-less datapath stages.
    always_comb begin
        trk_d[0].v   = gnt_any;
        trk_d[0].id  = gnt_id;
        trk_d[0].tag = gnt_any ? req_tag[gnt_id] : '0;
        for (int unsigned i = 1; i < PIPE_D; i++) begin
            trk_d[i] = trk_q[i-1];
        end
    end

    // Capture the datapath result alongside its tracked id/tag; update credits.
    always_comb begin
        fifo_wr          = trk_q[PIPE_D-1].v;
        fifo_wdata.id    = trk_q[PIPE_D-1].id;
        fifo_wdata.tag   = trk_q[PIPE_D-1].tag;
        fifo_wdata.res   = dp_res;
        fifo_wdata.flags = mul_flags_t'(dp_flags);
        pop              = rsp_valid && rsp_ready;
        occ_d            = occ_q;
        if (gnt_any && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!gnt_any && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= '0;
            prio_q <= 1'b0;
            for (int unsigned i = 0; i < PIPE_D; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            occ_q  <= occ_d;
            prio_q <= prio_d;
            for (int unsigned i = 0; i < PIPE_D; i++) begin
                trk_q[i] <= trk_d[i];
            end
        end
    end

    mul_ctrl_fifo #(
        .DEPTH   (FIFO_D),
        .entry_t (rsp_ent_t)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (fifo_wr),
        .wr_data_i  (fifo_wdata),
        .full_o     (fifo_full),
        .rd_en_i    (rsp_ready),
        .rd_valid_o (rsp_valid),
        .rd_data_o  (fifo_head)
    );

    // Unpack the FIFO head onto the response port.
    always_comb begin
        rsp_id    = fifo_head.id;
        rsp_tag   = fifo_head.tag;
        rsp_res   = fifo_head.res;
        rsp_flags = fifo_head.flags;
    end

    // The credit pool must make a full FIFO at write time impossible.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst) fifo_wr |-> !fifo_full)
        else $error("mul_issue_ctrl: response FIFO written while full");

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench: DUT A (PIPE_D=4, FIFO_D=6) and DUT B (PIPE_D=4, FIFO_D=2),
// each fed by its own behavioural fixed-latency datapath model.
module tb_mul_issue_ctrl;
    import mul_ctrl_pkg::*;

    localparam int unsigned PIPE_D = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]       a_req_valid, a_req_ready, b_req_valid, b_req_ready;
    logic [1:0][3:0]  a_req_tag, b_req_tag;
    logic [1:0][31:0] a_req_a, a_req_b, b_req_a, b_req_b;
    logic [1:0][1:0]  a_req_rnd, b_req_rnd;
    logic             a_dp_valid, b_dp_valid;
    logic [31:0]      a_dp_a, a_dp_b, a_dp_res, b_dp_a, b_dp_b, b_dp_res;
    logic [1:0]       a_dp_rnd, b_dp_rnd;
    logic [4:0]       a_dp_flags, b_dp_flags;
    logic             a_rsp_valid, a_rsp_ready, a_rsp_id, b_rsp_valid, b_rsp_ready, b_rsp_id;
    logic [3:0]       a_rsp_tag, b_rsp_tag;
    logic [31:0]      a_rsp_res, b_rsp_res;
    logic [4:0]       a_rsp_flags, b_rsp_flags;

    // Behavioural datapath function and stimulus generators.
    function automatic logic [31:0] m_res(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] r);
        return (x ^ y) + {30'd0, r};
    endfunction
    function automatic logic [4:0] m_flg(input logic [31:0] x, input logic [31:0] y,
                                         input logic [1:0] r);
        return x[4:0] ^ y[4:0] ^ {3'd0, r};
    endfunction
    function automatic logic [31:0] op_a(input int i, input int k);
        return 32'(32'h0100_0000 * (i + 1) + k);
    endfunction
    function automatic logic [31:0] op_b(input int i, input int k);
        return 32'(48 + 5 * k + i);
    endfunction
    function automatic logic [1:0] op_r(input int i, input int k);
        return 2'(k + i);
    endfunction

    // Free-running datapath models, PIPE_D cycles from operands to result.
    logic [36:0] a_pipe [PIPE_D];
    logic [36:0] b_pipe [PIPE_D];
    always @(posedge clk) begin
        a_pipe[0] <= {m_flg(a_dp_a, a_dp_b, a_dp_rnd), m_res(a_dp_a, a_dp_b, a_dp_rnd)};
        b_pipe[0] <= {m_flg(b_dp_a, b_dp_b, b_dp_rnd), m_res(b_dp_a, b_dp_b, b_dp_rnd)};
        for (int i = 1; i < PIPE_D; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
        end
    end
    assign a_dp_res   = a_pipe[PIPE_D-1][31:0];
    assign a_dp_flags = a_pipe[PIPE_D-1][36:32];
    assign b_dp_res   = b_pipe[PIPE_D-1][31:0];
    assign b_dp_flags = b_pipe[PIPE_D-1][36:32];

    mul_issue_ctrl #(.PIPE_D(PIPE_D), .FIFO_D(6), .TAG_W(4), .DATA_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_tag(a_req_tag), .req_a(a_req_a), .req_b(a_req_b), .req_rnd(a_req_rnd),
        .dp_valid(a_dp_valid), .dp_a(a_dp_a), .dp_b(a_dp_b), .dp_rnd(a_dp_rnd),
        .dp_res(a_dp_res), .dp_flags(a_dp_flags), .rsp_valid(a_rsp_valid),
        .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id), .rsp_tag(a_rsp_tag),
        .rsp_res(a_rsp_res), .rsp_flags(a_rsp_flags)
    );

    mul_issue_ctrl #(.PIPE_D(PIPE_D), .FIFO_D(2), .TAG_W(4), .DATA_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_tag(b_req_tag), .req_a(b_req_a), .req_b(b_req_b), .req_rnd(b_req_rnd),
        .dp_valid(b_dp_valid), .dp_a(b_dp_a), .dp_b(b_dp_b), .dp_rnd(b_dp_rnd),
        .dp_res(b_dp_res), .dp_flags(b_dp_flags), .rsp_valid(b_rsp_valid),
        .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_tag(b_rsp_tag),
        .rsp_res(b_rsp_res), .rsp_flags(b_rsp_flags)
    );

    task automatic idle_inputs();
        a_req_valid = '0; a_req_tag = '0; a_req_a = '0; a_req_b = '0; a_req_rnd = '0;
        b_req_valid = '0; b_req_tag = '0; b_req_a = '0; b_req_b = '0; b_req_rnd = '0;
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
    endtask

    // Leaves the bench at a falling edge with reset released.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        a_req_valid = 2'b11; a_req_a = {32'hDEAD_BEEF, 32'h1234_5678}; a_req_rnd = {2'd3, 2'd2};
        b_req_valid = 2'b11; b_req_b = {32'hCAFE_F00D, 32'h0BAD_0BAD};
        a_rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (a_req_ready !== 2'b00 || a_dp_valid !== 1'b0 || a_dp_a !== '0 || a_dp_b !== '0
            || a_dp_rnd !== '0) begin
            n_fail++;
            $display("FAIL reset_issue: req_ready=%b dp_valid=%b dp_a=%h dp_b=%h dp_rnd=%b, required all zero",
                     a_req_ready, a_dp_valid, a_dp_a, a_dp_b, a_dp_rnd);
        end
        n_tests++;
        if (a_rsp_valid !== 1'b0 || a_rsp_id !== 1'b0 || a_rsp_tag !== '0 || a_rsp_res !== '0
            || a_rsp_flags !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b id=%b tag=%h res=%h flags=%b, required all zero",
                     a_rsp_valid, a_rsp_id, a_rsp_tag, a_rsp_res, a_rsp_flags);
        end
        n_tests++;
        if (b_req_ready !== 2'b00 || b_dp_valid !== 1'b0 || b_dp_b !== '0 || b_rsp_valid !== 1'b0)
        begin
            n_fail++;
            $display("FAIL reset_dut_b: req_ready=%b dp_valid=%b dp_b=%h rsp_valid=%b, required zero",
                     b_req_ready, b_dp_valid, b_dp_b, b_rsp_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        a_rsp_ready = 1'b1;
        a_req_valid = 2'b01; a_req_tag[0] = 4'd3; a_req_rnd[0] = 2'd0;
        a_req_a[0] = 32'h3F80_0000; a_req_b[0] = 32'h4000_0000;
        a_req_a[1] = 32'hFFFF_FFFF;
        #1;
        n_tests++;
        if (a_req_ready !== 2'b01 || a_dp_valid !== 1'b1 || a_dp_a !== 32'h3F80_0000
            || a_dp_b !== 32'h4000_0000 || a_dp_rnd !== 2'd0) begin
            n_fail++;
            $display("FAIL single_issue: req_ready=%b dp_valid=%b dp_a=%h dp_b=%h, required 01 1 3f800000 40000000",
                     a_req_ready, a_dp_valid, a_dp_a, a_dp_b);
        end
        @(negedge clk);
        a_req_valid = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            #1;
            n_tests++;
            if (k == 5) begin
                if (a_rsp_valid !== 1'b1 || a_rsp_id !== 1'b0 || a_rsp_tag !== 4'd3
                    || a_rsp_res !== 32'h7F80_0000 || a_rsp_flags !== 5'd0) begin
                    n_fail++;
                    $display("FAIL single_rsp: valid=%b id=%b tag=%h res=%h flags=%b, required 1 0 3 7f800000 00000",
                             a_rsp_valid, a_rsp_id, a_rsp_tag, a_rsp_res, a_rsp_flags);
                end
            end else if (a_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_quiet: cycle %0d rsp_valid=%b, required 0", k, a_rsp_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alternate();
        int j;
        int id;
        logic [1:0] exp_rdy;
        do_reset();
        a_rsp_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k < 8) begin
                a_req_valid = 2'b11;
                for (int i = 0; i < 2; i++) begin
                    a_req_tag[i] = 4'(k + 8 * i);
                    a_req_a[i]   = op_a(i, k);
                    a_req_b[i]   = op_b(i, k);
                    a_req_rnd[i] = op_r(i, k);
                end
            end else begin
                a_req_valid = 2'b00;
            end
            #1;
            if (k < 8) begin
                exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
                n_tests++;
                if (a_req_ready !== exp_rdy || a_dp_a !== op_a(k % 2, k)) begin
                    n_fail++;
                    $display("FAIL alt_grant: cycle %0d req_ready=%b dp_a=%h, required %b %h",
                             k, a_req_ready, a_dp_a, exp_rdy, op_a(k % 2, k));
                end
            end
            n_tests++;
            if (k >= 5 && k < 13) begin
                j  = k - 5;
                id = j % 2;
                if (a_rsp_valid !== 1'b1 || a_rsp_id !== 1'(id) || a_rsp_tag !== 4'(j + 8 * id)
                    || a_rsp_res !== m_res(op_a(id, j), op_b(id, j), op_r(id, j))
                    || a_rsp_flags !== m_flg(op_a(id, j), op_b(id, j), op_r(id, j))) begin
                    n_fail++;
                    $display("FAIL alt_rsp: cycle %0d valid=%b id=%b tag=%h res=%h, required 1 %0d %h %h",
                             k, a_rsp_valid, a_rsp_id, a_rsp_tag, a_rsp_res, id,
                             4'(j + 8 * id), m_res(op_a(id, j), op_b(id, j), op_r(id, j)));
                end
            end else if (a_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL alt_quiet: cycle %0d rsp_valid=%b, required 0", k, a_rsp_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  exp_rdy;
        logic [31:0] head0_res;
        do_reset();
        head0_res = m_res(op_a(0, 0), op_b(0, 0), op_r(0, 0));
        a_req_valid = 2'b01;
        for (int k = 0; k < 15; k++) begin
            a_req_tag[0] = 4'(k);
            a_req_a[0]   = op_a(0, k);
            a_req_b[0]   = op_b(0, k);
            a_req_rnd[0] = op_r(0, k);
            a_rsp_ready  = (k == 12);
            #1;
            exp_rdy = (k < 6 || k == 13) ? 2'b01 : 2'b00;
            n_tests++;
            if (a_req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL bp_credit: cycle %0d req_ready=%b, required %b", k, a_req_ready, exp_rdy);
            end
            if (k >= 5) begin
                n_tests++;
                if (k <= 12 && (a_rsp_valid !== 1'b1 || a_rsp_tag !== 4'd0 || a_rsp_res !== head0_res))
                begin
                    n_fail++;
                    $display("FAIL bp_hold: cycle %0d valid=%b tag=%h res=%h, required 1 0 %h",
                             k, a_rsp_valid, a_rsp_tag, a_rsp_res, head0_res);
                end else if (k > 12 && (a_rsp_valid !== 1'b1 || a_rsp_tag !== 4'd1)) begin
                    n_fail++;
                    $display("FAIL bp_next_head: cycle %0d valid=%b tag=%h, required 1 1",
                             k, a_rsp_valid, a_rsp_tag);
                end
            end
            @(negedge clk);
        end
        a_req_valid = 2'b00;
        a_rsp_ready = 1'b1;
        repeat (14) @(negedge clk);
        #1;
        n_tests++;
        if (a_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: rsp_valid=%b, required 0", a_rsp_valid);
        end
    endtask

    task automatic test_credit_limited();
        logic [1:0] exp_rdy;
        logic       exp_v;
        do_reset();
        b_rsp_ready = 1'b1;
        b_req_valid = 2'b10;
        for (int k = 0; k < 20; k++) begin
            b_req_tag[1] = 4'(k);
            b_req_a[1]   = op_a(1, k);
            b_req_b[1]   = op_b(1, k);
            b_req_rnd[1] = op_r(1, k);
            #1;
            // Two credits, six-cycle credit round trip: bursts of two every six cycles.
            exp_rdy = (k % 6 < 2) ? 2'b10 : 2'b00;
            exp_v   = (k >= 5) && ((k - 5) % 6 < 2);
            n_tests++;
            if (b_req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL credit_issue: cycle %0d req_ready=%b, required %b", k, b_req_ready, exp_rdy);
            end
            n_tests++;
            if (b_rsp_valid !== exp_v || (exp_v && (b_rsp_tag !== 4'(k - 5) || b_rsp_id !== 1'b1
                || b_rsp_res !== m_res(op_a(1, k - 5), op_b(1, k - 5), op_r(1, k - 5))))) begin
                n_fail++;
                $display("FAIL credit_rsp: cycle %0d valid=%b tag=%h id=%b, required valid %b",
                         k, b_rsp_valid, b_rsp_tag, b_rsp_id, exp_v);
            end
            @(negedge clk);
        end
        b_req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_req_valid = 2'b01;
        for (int k = 0; k < 6; k++) begin
            a_req_valid  = (k < 5) ? 2'b01 : 2'b00;
            a_req_tag[0] = 4'(k + 1);
            a_req_a[0]   = op_a(0, k);
            a_req_b[0]   = op_b(0, k);
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (a_rsp_valid !== 1'b1 || a_rsp_tag !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_prefill: valid=%b tag=%h, required 1 1", a_rsp_valid, a_rsp_tag);
        end
        rst = 1'b1;
        a_req_valid = 2'b11;
        a_req_a = {32'h1111_1111, 32'h2222_2222};
        #1;
        n_tests++;
        if (a_req_ready !== 2'b00 || a_dp_valid !== 1'b0 || a_dp_a !== '0 || a_rsp_valid !== 1'b0
            || a_rsp_tag !== '0 || a_rsp_res !== '0 || a_rsp_flags !== '0 || a_rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: req_ready=%b dp_valid=%b rsp_valid=%b tag=%h res=%h, required zero",
                     a_req_ready, a_dp_valid, a_rsp_valid, a_rsp_tag, a_rsp_res);
        end
        @(negedge clk);
        rst = 1'b0;
        a_req_valid = 2'b00;
        a_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if (a_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_stale: cycle %0d rsp_valid=%b, required 0", k, a_rsp_valid);
            end
            @(negedge clk);
        end
        a_req_valid = 2'b11;
        #1;
        n_tests++;
        if (a_req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_prio: req_ready=%b, required 01", a_req_ready);
        end
        @(negedge clk);
        a_req_valid = 2'b00;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_credit_limited();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
